// File: rtl/keypad_scan_if.sv
// Keypad pin bundle plus the key code output toward the game core.
// The master side is the scanner and the slave side is the board or game core.
interface keypad_scan_if;
   logic [2:0] key_col;
   logic [3:0] key_row;
   logic [3:0] key_data;
   logic       key_valid;

   modport master (
      input  key_col,
      output key_row,
      output key_data,
      output key_valid
   );

   modport slave (
      output key_col,
      input  key_row,
      input  key_data,
      input  key_valid
   );
endinterface

// File: rtl/keypad_scan.sv
// 3x4 matrix keypad scanner: drives one row low at a time, debounces the columns
// on a prescaled tick, and reports each physical press once as a 1-12 code.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | rotate the active row each tick, looking for a single low column
// DEBOUNCE | row frozen, counting identical samples of the candidate key
// HOLD     | key accepted and reported, row frozen until the columns go high
// RELEASE  | counting consecutive none samples before the code is cleared
module keypad_scan #(
   parameter int CLK_DIV      = 25000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   keypad_scan_if.master kp
);

   localparam int              PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_TC = PW'(CLK_DIV - 1);
   localparam logic [3:0]      DB_TC  = 4'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t        state_q, state_n;
   logic [PW-1:0] pre_q;
   logic          tick;
   logic [2:0]    col_m, col_s;
   logic [1:0]    row_idx_q, row_idx_n;
   logic [3:0]    row_q, row_n;
   logic [3:0]    cnt_q, cnt_n;
   logic [3:0]    cand_q, cand_n;
   logic [3:0]    data_q, data_n;
   logic          valid_q, valid_n;

   logic          samp_key;
   logic [1:0]    samp_col;
   logic [3:0]    samp_code;

   // Columns are asynchronous to clk and pulled high when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_m <= 3'b111;
         col_s <= 3'b111;
      end else begin
         col_m <= kp.key_col;
         col_s <= col_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   assign tick = (pre_q == PRE_TC);

   // Only a single low column is a key; two or more low columns count as none.
   always_comb begin
      samp_key = 1'b1;
      samp_col = 2'd0;
      case (col_s)
         3'b110:  samp_col = 2'd0;
         3'b101:  samp_col = 2'd1;
         3'b011:  samp_col = 2'd2;
         default: samp_key = 1'b0;
      endcase
      samp_code = {2'b00, row_idx_q} + {1'b0, row_idx_q, 1'b0}
                + {2'b00, samp_col} + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SCAN;
         row_idx_q <= 2'd0;
         row_q     <= 4'b1110;
         cnt_q     <= 4'd0;
         cand_q    <= 4'd0;
         data_q    <= 4'd0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_n;
         row_idx_q <= row_idx_n;
         row_q     <= row_n;
         cnt_q     <= cnt_n;
         cand_q    <= cand_n;
         data_q    <= data_n;
         valid_q   <= valid_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      row_idx_n = row_idx_q;
      cnt_n     = cnt_q;
      cand_n    = cand_q;
      data_n    = data_q;
      valid_n   = 1'b0;

      if (tick) begin
         case (state_q)
            SCAN: begin
               if (samp_key) begin
                  cand_n = samp_code;
                  cnt_n  = 4'd1;
                  if (DB_TC == 4'd1) begin
                     data_n  = samp_code;
                     valid_n = 1'b1;
                     state_n = HOLD;
                  end else begin
                     state_n = DEBOUNCE;
                  end
               end else begin
                  row_idx_n = row_idx_q + 2'd1;
               end
            end

            DEBOUNCE: begin
               if (samp_key && (samp_code == cand_q)) begin
                  cnt_n = cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) == DB_TC) begin
                     data_n  = cand_q;
                     valid_n = 1'b1;
                     state_n = HOLD;
                  end
               end else begin
                  cnt_n     = 4'd0;
                  row_idx_n = row_idx_q + 2'd1;
                  state_n   = SCAN;
               end
            end

            HOLD: begin
               if (!samp_key) begin
                  cnt_n = 4'd1;
                  if (DB_TC == 4'd1) begin
                     data_n    = 4'd0;
                     cnt_n     = 4'd0;
                     row_idx_n = row_idx_q + 2'd1;
                     state_n   = SCAN;
                  end else begin
                     state_n = RELEASE;
                  end
               end
            end

            RELEASE: begin
               // A key reappearing here is bounce on the held key, never a new report.
               if (!samp_key) begin
                  cnt_n = cnt_q + 4'd1;
                  if ((cnt_q + 4'd1) == DB_TC) begin
                     data_n    = 4'd0;
                     cnt_n     = 4'd0;
                     row_idx_n = row_idx_q + 2'd1;
                     state_n   = SCAN;
                  end
               end else begin
                  cnt_n   = 4'd0;
                  state_n = HOLD;
               end
            end

            default: begin
               state_n = SCAN;
            end
         endcase
      end

      row_n = ~(4'b0001 << row_idx_n);
   end

   assign kp.key_row   = row_q;
   assign kp.key_data  = data_q;
   assign kp.key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a behavioural keypad drives the columns from
// the pressed-key set and the active row; a monitor checks every key_valid pulse.
module tb_keypad_scan;

   localparam int CLK_DIV = 4;
   localparam int DB      = 3;
   localparam int TK      = CLK_DIV;

   typedef struct {
      logic [3:0] code;
      logic [3:0] row;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] pressed;
   logic [2:0]  col;
   logic        prev_valid;
   exp_t        exp_q[$];
   int          checks;
   int          errors;

   keypad_scan_if kp ();

   keypad_scan #(
      .CLK_DIV      (CLK_DIV),
      .DEBOUNCE_CNT (DB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      col = 3'b111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (!kp.key_row[r] && pressed[3*r + c + 1]) col[c] = 1'b0;
         end
      end
      kp.key_col = col;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] row_of(input int code);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << ((code - 1) / 3));
   endfunction

   always @(negedge clk) begin
      if (rst_n && kp.key_valid) begin
         chk("valid_gap", int'(prev_valid), 0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got key_data=%0d with key_valid=1, expected no pulse (t=%0t)",
                     kp.key_data, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("valid_data", int'(kp.key_data), int'(e.code));
            chk("valid_row", int'(kp.key_row), int'(e.row));
         end
      end
      prev_valid = kp.key_valid;
   end

   // Returns on the negedge right after key_row has just switched to target,
   // so the first sampling tick of that row is three clk later.
   task automatic wait_row(input logic [3:0] target);
      int n;
      n = 0;
      while (kp.key_row == target && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (kp.key_row != target && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("wait_row_timeout", int'(n < 64), 1);
   endtask

   task automatic press_key(input int code, input int ticks);
      logic [3:0] r;
      r = row_of(code);
      wait_row(r);
      exp_q.push_back('{code: 4'(code), row: r});
      pressed[code] = 1'b1;
      repeat (ticks * TK) @(negedge clk);
      chk("held_data", int'(kp.key_data), code);
      chk("held_row", int'(kp.key_row), int'(r));
      pressed = '0;
      repeat (6 * TK) @(negedge clk);
      chk("release_data", int'(kp.key_data), 0);
      chk("pending", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r0;
      checks     = 0;
      errors     = 0;
      prev_valid = 1'b0;
      pressed    = '0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 1. reset mid-scan, then free-running row rotation
      rst_n = 1'b0;
      #1;
      chk("rst_row", int'(kp.key_row), 4'b1110);
      chk("rst_data", int'(kp.key_data), 0);
      chk("rst_valid", int'(kp.key_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 3)  chk("row_k3", int'(kp.key_row), 4'b1110);
         if (k == 4)  chk("row_k4", int'(kp.key_row), 4'b1101);
         if (k == 8)  chk("row_k8", int'(kp.key_row), 4'b1011);
         if (k == 12) chk("row_k12", int'(kp.key_row), 4'b0111);
         if (k == 16) chk("row_k16", int'(kp.key_row), 4'b1110);
      end

      // 2. clean press of "5", then scanning must resume
      press_key(5, 40);
      r0 = kp.key_row;
      repeat (TK) @(negedge clk);
      chk("scan_resumed", int'(kp.key_row != r0), 1);

      // 3. bouncing press and release of "9"
      wait_row(4'b1011);
      exp_q.push_back('{code: 4'd9, row: 4'b1011});
      for (int i = 0; i < 6; i++) begin
         pressed[9] = (i % 2 == 0);
         repeat (TK) @(negedge clk);
      end
      pressed[9] = 1'b1;
      repeat (30 * TK) @(negedge clk);
      chk("bounce_data", int'(kp.key_data), 9);
      pressed[9] = 1'b0;
      repeat (TK) @(negedge clk);
      pressed[9] = 1'b1;
      repeat (TK) @(negedge clk);
      pressed[9] = 1'b0;
      repeat (8 * TK) @(negedge clk);
      chk("bounce_release", int'(kp.key_data), 0);
      chk("bounce_pending", exp_q.size(), 0);

      // 4. two-tick glitch on "7" in row 2
      wait_row(4'b1011);
      pressed[7] = 1'b1;
      repeat (2 * TK) @(negedge clk);
      pressed[7] = 1'b0;
      repeat (6) @(negedge clk);
      chk("glitch_data", int'(kp.key_data), 0);
      chk("glitch_next_row", int'(kp.key_row), 4'b0111);

      // 5. multi-key in one row, then the control keys
      wait_row(4'b1101);
      pressed[4] = 1'b1;
      pressed[5] = 1'b1;
      repeat (20 * TK) @(negedge clk);
      chk("multi_data", int'(kp.key_data), 0);
      pressed = '0;
      repeat (2 * TK) @(negedge clk);
      press_key(12, 30);
      press_key(10, 30);
      press_key(11, 30);

      // 6. reset while "1" is held, key still held afterwards
      wait_row(4'b1110);
      exp_q.push_back('{code: 4'd1, row: 4'b1110});
      pressed[1] = 1'b1;
      repeat (30 * TK) @(negedge clk);
      chk("hold1_data", int'(kp.key_data), 1);
      rst_n = 1'b0;
      #1;
      chk("hold_rst_data", int'(kp.key_data), 0);
      chk("hold_rst_row", int'(kp.key_row), 4'b1110);
      chk("hold_rst_valid", int'(kp.key_valid), 0);
      repeat (3) @(negedge clk);
      exp_q.push_back('{code: 4'd1, row: 4'b1110});
      rst_n = 1'b1;
      repeat (30 * TK) @(negedge clk);
      chk("redetect_data", int'(kp.key_data), 1);
      pressed = '0;
      repeat (8 * TK) @(negedge clk);
      chk("redetect_release", int'(kp.key_data), 0);
      chk("final_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
